unidade_controle_jogo: RTL and testbench

- Moore FSM that sequences the memory-game datapath.
- Per round: fetches the next LED pattern, shows it for a fixed time, blanks it, then waits for the player's press under a timeout. It registers and compares the press, then advances or ends the game.
- Drives every zera*/registra*/conta* control of the datapath and consumes its status flags: fimS, tem_jogada, acertouJogada, timeout.
- Sits beside the datapath inside the game top level.

---
 rtl/unidade_controle_jogo.sv | 147 ++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogo.sv
// ============================================================================
// unidade_controle_jogo : Moore FSM sequencing the memory-game datapath
// Revision 1.0
// ============================================================================
`default_nettype none

module unidade_controle_jogo #(
  parameter int T_EXIBE = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fimS,
  input  logic       tem_jogada,
  input  logic       acertouJogada,
  input  logic       timeout,
  output logic       zeraT,
  output logic       zeraS,
  output logic       contaS,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraA,
  output logic       registraA,
  output logic       zeraL,
  output logic       registraL,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  localparam int CW = $clog2(T_EXIBE) + 1;

  typedef enum logic [3:0] {
    ST_INICIAL      = 4'h0,
    ST_PREPARACAO   = 4'h1,
    ST_BUSCA        = 4'h2,
    ST_MOSTRA       = 4'h3,
    ST_EXIBE        = 4'h4,
    ST_APAGA        = 4'h5,
    ST_ESPERA       = 4'h6,
    ST_REGISTRA     = 4'h7,
    ST_COMPARACAO   = 4'h8,
    ST_PROXIMA      = 4'h9,
    ST_GANHOU       = 4'hA,
    ST_PERDEU_ERRO  = 4'hB,
    ST_PERDEU_TEMPO = 4'hC
  } estado_t;

  estado_t         estado_q, estado_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= ST_INICIAL;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    case (estado_q)
      ST_INICIAL:    if (iniciar) estado_d = ST_PREPARACAO;
      ST_PREPARACAO: estado_d = ST_BUSCA;
      ST_BUSCA:      estado_d = ST_MOSTRA;
      ST_MOSTRA: begin
        estado_d = ST_EXIBE;
        cnt_d    = '0;
      end
      ST_EXIBE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(T_EXIBE - 1)) estado_d = ST_APAGA;
      end
      ST_APAGA:      estado_d = ST_ESPERA;
      // A press in the same cycle as the timeout still counts as a reply.
      ST_ESPERA: begin
        if (tem_jogada)   estado_d = ST_REGISTRA;
        else if (timeout) estado_d = ST_PERDEU_TEMPO;
      end
      ST_REGISTRA:   estado_d = ST_COMPARACAO;
      ST_COMPARACAO: begin
        if (!acertouJogada) estado_d = ST_PERDEU_ERRO;
        else if (fimS)      estado_d = ST_GANHOU;
        else                estado_d = ST_PROXIMA;
      end
      ST_PROXIMA:    estado_d = ST_BUSCA;
      ST_GANHOU, ST_PERDEU_ERRO, ST_PERDEU_TEMPO:
        if (iniciar) estado_d = ST_PREPARACAO;
      default:       estado_d = ST_INICIAL;
    endcase
  end

  always_comb begin
    zeraT     = 1'b0;
    zeraS     = 1'b0;
    contaS    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    zeraA     = 1'b0;
    registraA = 1'b0;
    zeraL     = 1'b0;
    registraL = 1'b0;
    pronto    = 1'b0;
    ganhou    = 1'b0;
    perdeu    = 1'b0;
    case (estado_q)
      ST_PREPARACAO: begin
        zeraS = 1'b1;
        zeraR = 1'b1;
        zeraA = 1'b1;
        zeraL = 1'b1;
        zeraT = 1'b1;
      end
      ST_MOSTRA: begin
        registraL = 1'b1;
        zeraR     = 1'b1;
      end
      ST_APAGA: begin
        zeraL = 1'b1;
        zeraT = 1'b1;
      end
      ST_REGISTRA: registraR = 1'b1;
      ST_PROXIMA: begin
        contaS    = 1'b1;
        registraA = 1'b1;
      end
      ST_GANHOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      ST_PERDEU_ERRO, ST_PERDEU_TEMPO: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_q;

endmodule

`default_nettype wire

// File: tb/tb_unidade_controle_jogo.sv
// ============================================================================
// tb_unidade_controle_jogo : scoreboard bench for the game control FSM
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_unidade_controle_jogo;

  localparam int T_EXIBE = 4;

  logic       clock = 1'b0;
  logic       reset, iniciar, fimS, tem_jogada, acertouJogada, timeout;
  logic       zeraT, zeraS, contaS, zeraR, registraR, zeraA, registraA;
  logic       zeraL, registraL, pronto, ganhou, perdeu;
  logic [3:0] db_estado;

  unidade_controle_jogo #(.T_EXIBE(T_EXIBE)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimS(fimS),
    .tem_jogada(tem_jogada), .acertouJogada(acertouJogada), .timeout(timeout),
    .zeraT(zeraT), .zeraS(zeraS), .contaS(contaS), .zeraR(zeraR),
    .registraR(registraR), .zeraA(zeraA), .registraA(registraA),
    .zeraL(zeraL), .registraL(registraL), .pronto(pronto), .ganhou(ganhou),
    .perdeu(perdeu), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         due;
    logic [3:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected controls per state, order:
  // zeraT zeraS contaS zeraR registraR zeraA registraA zeraL registraL pronto ganhou perdeu
  function automatic logic [11:0] exp_outs(input logic [3:0] st);
    case (st)
      4'h1:    return 12'b1_1_0_1_0_1_0_1_0_0_0_0;
      4'h3:    return 12'b0_0_0_1_0_0_0_0_1_0_0_0;
      4'h5:    return 12'b1_0_0_0_0_0_0_1_0_0_0_0;
      4'h7:    return 12'b0_0_0_0_1_0_0_0_0_0_0_0;
      4'h9:    return 12'b0_0_1_0_0_0_1_0_0_0_0_0;
      4'hA:    return 12'b0_0_0_0_0_0_0_0_0_1_1_0;
      4'hB,
      4'hC:    return 12'b0_0_0_0_0_0_0_0_0_1_0_1;
      default: return 12'b0;
    endcase
  endfunction

  // Monitor: pops every expectation due in the current cycle.
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t        e;
      logic [15:0] act, req;
      e   = exp_q.pop_front();
      act = {db_estado, zeraT, zeraS, contaS, zeraR, registraR, zeraA,
             registraA, zeraL, registraL, pronto, ganhou, perdeu};
      req = {e.st, exp_outs(e.st)};
      checks = checks + 1;
      if (act !== req) begin
        errors = errors + 1;
        $display("FAIL state/outputs cycle %0d: actual=%h required=%h", cyc, act, req);
      end
    end
  end

  // Drive inputs for one cycle; the state after the next edge must be st.
  task automatic step(input logic r, input logic ini, input logic tj,
                      input logic ac, input logic fs, input logic to,
                      input logic [3:0] st);
    exp_t e;
    reset = r; iniciar = ini; tem_jogada = tj;
    acertouJogada = ac; fimS = fs; timeout = to;
    e.due = cyc + 1;
    e.st  = st;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, st);
  endtask

  // From preparacao-bound start: preparacao..espera with full exibe.
  task automatic start_round();
    step(0, 1, 0, 0, 0, 0, 4'h1);
    idle(4'h2, 1);
    idle(4'h3, 1);
    idle(4'h4, T_EXIBE);
    idle(4'h5, 1);
    idle(4'h6, 1);
  endtask

  initial begin
    reset = 1; iniciar = 0; fimS = 0; tem_jogada = 0; acertouJogada = 0; timeout = 0;
    #1;
    // Reset and idle
    step(1, 0, 0, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 0, 0, 4'h0);
    idle(4'h0, 20);

    // Start sequencing
    start_round();
    // iniciar ignored while waiting for a reply
    step(0, 1, 0, 0, 0, 0, 4'h6);

    // Correct press, not last
    step(0, 0, 1, 1, 0, 0, 4'h7);
    step(0, 0, 0, 1, 0, 0, 4'h8);
    step(0, 0, 0, 1, 0, 0, 4'h9);
    idle(4'h2, 1);
    idle(4'h3, 1);
    idle(4'h4, T_EXIBE);
    idle(4'h5, 1);
    idle(4'h6, 1);

    // Win
    step(0, 0, 1, 1, 1, 0, 4'h7);
    step(0, 0, 0, 1, 1, 0, 4'h8);
    step(0, 0, 0, 1, 1, 0, 4'hA);
    idle(4'hA, 3);
    start_round();

    // Wrong press; held loss ignores press/timeout
    step(0, 0, 1, 1, 0, 0, 4'h7);
    step(0, 0, 0, 0, 0, 0, 4'h8);
    step(0, 0, 0, 0, 0, 0, 4'hB);
    step(0, 0, 1, 1, 1, 1, 4'hB);
    start_round();

    // Timeout
    step(0, 0, 0, 0, 0, 1, 4'hC);
    idle(4'hC, 2);
    start_round();

    // Simultaneous press and timeout, then reset mid-exibe
    step(0, 0, 1, 1, 0, 1, 4'h7);
    step(0, 0, 0, 1, 0, 0, 4'h8);
    step(0, 0, 0, 1, 0, 0, 4'h9);
    idle(4'h2, 1);
    idle(4'h3, 1);
    idle(4'h4, 2);
    step(1, 0, 0, 0, 0, 0, 4'h0);
    idle(4'h0, 2);
    start_round();

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
